// File: rtl/wallace_tree_multiplier_8bit.sv
// Unsigned 8x8 -> 16 Wallace-tree multiplier: AND-array, 3:2 reduction in four stages, ripple adder, output register.
// Optional macro WALLACE_PIPE_EN registers the two reduced rows ahead of the final adder (2-cycle latency).

module wallace_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module wallace_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// Row-wide 3:2 compressor; the weight-2^16 carry cannot be set for 8x8 operands and is exposed only for tie-off.
module wallace_csa (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  output logic [15:0] sum,
  output logic [15:0] carry,
  output logic        cout
);
  logic [15:0] co;

  for (genvar k = 0; k < 16; k++) begin : g_fa
    wallace_fa u_fa (.a(x[k]), .b(y[k]), .ci(z[k]), .s(sum[k]), .co(co[k]));
  end

  assign carry = {co[14:0], 1'b0};
  assign cout  = co[15];
endmodule

module wallace_tree_multiplier_8bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        in_vld,
  output logic [15:0] result,
  output logic        out_vld
);
  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 16;

  logic [RES_W-1:0] pp [OP_W];
  logic [RES_W-1:0] s1a, c1a, s1b, c1b;
  logic [RES_W-1:0] s2a, c2a, s2b, c2b;
  logic [RES_W-1:0] s3a, c3a;
  logic [RES_W-1:0] row_x, row_y;
  logic [RES_W-1:0] add_x, add_y;
  logic             add_vld;
  logic [RES_W-1:0] sum;
  logic [RES_W-1:0] rc;
  logic [6:0]       unused_cout;

  // Partial-product rows, row i shifted left by i.
  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign pp[i] = RES_W'({OP_W{b[i]}} & a) << i;
  end

  // 8 -> 6
  wallace_csa u_csa1a (.x(pp[0]), .y(pp[1]), .z(pp[2]), .sum(s1a), .carry(c1a), .cout(unused_cout[0]));
  wallace_csa u_csa1b (.x(pp[3]), .y(pp[4]), .z(pp[5]), .sum(s1b), .carry(c1b), .cout(unused_cout[1]));
  // 6 -> 4
  wallace_csa u_csa2a (.x(s1a), .y(c1a), .z(s1b), .sum(s2a), .carry(c2a), .cout(unused_cout[2]));
  wallace_csa u_csa2b (.x(c1b), .y(pp[6]), .z(pp[7]), .sum(s2b), .carry(c2b), .cout(unused_cout[3]));
  // 4 -> 3
  wallace_csa u_csa3 (.x(s2a), .y(c2a), .z(s2b), .sum(s3a), .carry(c3a), .cout(unused_cout[4]));
  // 3 -> 2
  wallace_csa u_csa4 (.x(s3a), .y(c3a), .z(c2b), .sum(row_x), .carry(row_y), .cout(unused_cout[5]));

`ifdef WALLACE_PIPE_EN
  logic [RES_W-1:0] row_x_q, row_y_q;
  logic             pipe_vld;

  // Reduced rows are captured only for valid operands so idle-cycle garbage never reaches the adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_x_q  <= '0;
      row_y_q  <= '0;
      pipe_vld <= 1'b0;
    end else begin
      pipe_vld <= in_vld;
      if (in_vld) begin
        row_x_q <= row_x;
        row_y_q <= row_y;
      end
    end
  end

  assign add_x   = row_x_q;
  assign add_y   = row_y_q;
  assign add_vld = pipe_vld;
`else
  assign add_x   = row_x;
  assign add_y   = row_y;
  assign add_vld = in_vld;
`endif

  // Final ripple carry-propagate adder.
  wallace_ha u_add0 (.a(add_x[0]), .b(add_y[0]), .s(sum[0]), .c(rc[0]));
  for (genvar k = 1; k < RES_W; k++) begin : g_rca
    wallace_fa u_add (.a(add_x[k]), .b(add_y[k]), .ci(rc[k-1]), .s(sum[k]), .co(rc[k]));
  end
  assign unused_cout[6] = rc[RES_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= add_vld;
      if (add_vld) begin
        result <= sum;
      end
    end
  end
endmodule

// File: tb/tb_wallace_tree_multiplier_8bit.sv
// Bench for wallace_tree_multiplier_8bit: directed, streaming, random and exhaustive products vs a*b.

module tb_wallace_tree_multiplier_8bit;
`ifdef WALLACE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        in_vld;
  logic [15:0] result;
  logic        out_vld;

  int checks;
  int failures;

  // Model: in-flight operations and the held output value.
  logic        pv [LAT];
  logic [15:0] pr [LAT];
  logic        mvld;
  logic [15:0] mres;

  wallace_tree_multiplier_8bit dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .in_vld  (in_vld),
    .result  (result),
    .out_vld (out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag);
    checks++;
    assert (out_vld === mvld) else begin
      failures++;
      $error("FAIL %s out_vld observed=%0b expected=%0b", tag, out_vld, mvld);
    end
    checks++;
    assert (result === mres) else begin
      failures++;
      $error("FAIL %s result observed=%h expected=%h", tag, result, mres);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pr[i] = 16'h0;
    end
    mvld = 1'b0;
    mres = 16'h0;
  endtask

  // One clock: drive at negedge, check #1 after the rising edge.
  task automatic step(input logic v, input logic [7:0] x, input logic [7:0] y, input string tag);
    @(negedge clk);
    in_vld = v;
    a      = x;
    b      = y;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pr[i] = pr[i-1];
    end
    pv[0] = v;
    pr[0] = 16'(int'(x) * int'(y));
    @(posedge clk);
    #1;
    mvld = pv[LAT-1];
    if (pv[LAT-1]) mres = pr[LAT-1];
    check_out(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 8'($urandom), 8'($urandom), tag);
  endtask

  logic [7:0] va [9];
  logic [7:0] vb [9];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_vld   = 1'b0;
    a        = 8'h0;
    b        = 8'h0;
    model_clear();

    va = '{8'd2, 8'd15, 8'd255, 8'd0,   8'd255, 8'd128, 8'd127, 8'd170, 8'd204};
    vb = '{8'd3, 8'd15, 8'd1,   8'd255, 8'd255, 8'd128, 8'd127, 8'd85,  8'd51};

    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Put traffic in flight, then reset asynchronously between edges.
    step(1'b1, 8'd200, 8'd199, "pre_reset_a");
    step(1'b1, 8'd77,  8'd3,   "pre_reset_b");
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_out("async_reset");
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 8'd1, 8'd1, "one_x_one");
    for (int i = 1; i < LAT; i++) idle("one_x_one_lat");
    checks++;
    assert (result === 16'h0001) else begin
      failures++;
      $error("FAIL one_x_one_const result observed=%h expected=0001", result);
    end
    idle("gap");

    // Directed vectors, one at a time, with constant cross-checks on the product.
    for (int k = 0; k < 9; k++) begin
      step(1'b1, va[k], vb[k], $sformatf("directed_%0d", k));
      for (int i = 1; i < LAT; i++) idle($sformatf("directed_%0d_lat", k));
      idle($sformatf("directed_%0d_hold", k));
    end
    checks++;
    assert (result === 16'h28A4) else begin
      failures++;
      $error("FAIL last_directed_hold result observed=%h expected=28a4", result);
    end

    // Back-to-back stream, then one idle cycle to show hold with out_vld low.
    for (int k = 0; k < 9; k++) step(1'b1, va[k], vb[k], $sformatf("stream_%0d", k));
    for (int i = 0; i < LAT; i++) idle("stream_drain");
    idle("stream_hold");

    // Spot-check maximum product through the model path.
    step(1'b1, 8'hFF, 8'hFF, "max");
    for (int i = 1; i < LAT; i++) idle("max_lat");
    checks++;
    assert (result === 16'hFE01) else begin
      failures++;
      $error("FAIL max_const result observed=%h expected=fe01", result);
    end

    // Random operands with random valid.
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), "random");
    end

    // Exhaustive stream of every operand pair.
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        step(1'b1, 8'(x), 8'(y), "exhaustive");
      end
    end
    for (int i = 0; i < LAT + 1; i++) idle("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
